// File: rtl/dmul_uni_seq.sv
// dmul_uni_seq: operand sequencer and result capture for the unipolar
// LFSR stochastic multiplier. Optional feature macro: DMUL_ACC_EN.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   op_valid/op_ready     operand pair handshake (op_a, op_b, op_last)
//   mul_iA/mul_iB         operands driven to the multiplier
//   mul_loadA/mul_loadB   multiplier load strobes (one cycle in LOAD)
//   mul_oC                multiplier coincidence count
//   res_valid/res_ready   result handshake, res_data holds the result
//
// With DMUL_ACC_EN, products are summed (saturating) until op_last=1.

module dmul_uni_seq #(
  parameter int DATAWD    = 8,
  parameter int WIN_LEN   = 255,
  parameter int ACC_GUARD = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [DATAWD-1:0]             op_a,
  input  logic [DATAWD-1:0]             op_b,
  input  logic                          op_last,
  output logic [DATAWD-1:0]             mul_iA,
  output logic [DATAWD-1:0]             mul_iB,
  output logic                          mul_loadA,
  output logic                          mul_loadB,
  input  logic [2*DATAWD-1:0]           mul_oC,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [2*DATAWD+ACC_GUARD-1:0] res_data
);

  localparam int CW  = 2 * DATAWD;
  localparam int RW  = CW + ACC_GUARD;
  localparam int WCW = DATAWD + 1;

  localparam logic [WCW-1:0] WIN_LAST =
    WCW'(WIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAP,
    S_OUT
  } state_t;

  state_t         r_state;
  logic [WCW-1:0] r_win_cnt;
  logic           w_accept;

  assign w_accept = op_valid && op_ready;

`ifdef DMUL_ACC_EN
  logic [RW-1:0] r_acc;
  logic          r_last;
  logic [RW:0]   w_acc_sum;
  logic [RW-1:0] w_acc_sat;

  assign w_acc_sum = {1'b0, r_acc} +
                     (RW+1)'(mul_oC);

  // Clamp to all-ones on carry out.
  assign w_acc_sat = w_acc_sum[RW] ?
                     {RW{1'b1}} :
                     w_acc_sum[RW-1:0];
`else
  logic w_unused;

  assign w_unused = op_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_win_cnt <= '0;
      op_ready  <= 1'b0;
      mul_iA    <= '0;
      mul_iB    <= '0;
      mul_loadA <= 1'b0;
      mul_loadB <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef DMUL_ACC_EN
      r_acc     <= '0;
      r_last    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          op_ready <= 1'b1;
          if (w_accept) begin
            mul_iA    <= op_a;
            mul_iB    <= op_b;
            mul_loadA <= 1'b1;
            mul_loadB <= 1'b1;
            op_ready  <= 1'b0;
`ifdef DMUL_ACC_EN
            r_last    <= op_last;
`endif
            r_state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          mul_loadA <= 1'b0;
          mul_loadB <= 1'b0;
          r_win_cnt <= '0;
          r_state   <= S_RUN;
        end

        // Window counter reaches WIN_LEN at most, so
        // DATAWD+1 bits never wrap.
        S_RUN: begin
          r_win_cnt <= r_win_cnt + 1'b1;
          if (r_win_cnt == WIN_LAST) begin
            r_state <= S_CAP;
          end
        end

        S_CAP: begin
`ifdef DMUL_ACC_EN
          r_acc <= w_acc_sat;
          if (r_last) begin
            res_data  <= w_acc_sat;
            res_valid <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            op_ready <= 1'b1;
            r_state  <= S_IDLE;
          end
`else
          res_data  <= RW'(mul_oC);
          res_valid <= 1'b1;
          r_state   <= S_OUT;
`endif
        end

        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            r_state   <= S_IDLE;
`ifdef DMUL_ACC_EN
            r_acc     <= '0;
`endif
          end
        end

        default: begin
          op_ready <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmul_uni_seq.sv
// tb_dmul_uni_seq: directed bench for dmul_uni_seq with a
// deterministic stand-in for the stochastic multiplier.
`timescale 1ns/1ps

module tb_dmul_uni_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic        op_last = 1'b0;
  logic [7:0]  mul_iA;
  logic [7:0]  mul_iB;
  logic        mul_loadA;
  logic        mul_loadB;
  logic [15:0] mul_oC;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [23:0] res_data;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int nload = 0;
  int nhs = 0;
  int e0 = 0;

  dmul_uni_seq #(
    .DATAWD(8),
    .WIN_LEN(255),
    .ACC_GUARD(8)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_a(op_a),
    .op_b(op_b),
    .op_last(op_last),
    .mul_iA(mul_iA),
    .mul_iB(mul_iB),
    .mul_loadA(mul_loadA),
    .mul_loadB(mul_loadB),
    .mul_oC(mul_oC),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (mul_loadA) nload++;

  always @(posedge clk)
    if (res_valid && res_ready) nhs <= nhs + 1;

  // Stand-in multiplier: cleared by load, then counts one per
  // edge while both operands are nonzero, up to 2*A. Keeps
  // counting after the window so late capture is visible.
  logic [7:0]  m_a = '0;
  logic        m_nz = 1'b0;
  logic [15:0] m_cnt = '0;

  assign mul_oC = m_cnt;

  always @(posedge clk) begin
    if (mul_loadA && mul_loadB) begin
      m_a   <= mul_iA;
      m_nz  <= (mul_iA != 0) && (mul_iB != 0);
      m_cnt <= '0;
    end else if (m_nz && m_cnt < {7'd0, m_a, 1'b0}) begin
      m_cnt <= m_cnt + 1'b1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves op_valid high; caller drops it when done.
  task automatic send(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic       last);
    int   n;
    logic rdy;
    n = 0;
    op_a = a;
    op_b = b;
    op_last = last;
    op_valid = 1'b1;
    do begin
      rdy = op_ready;
      tick();
      n++;
    end while (!rdy && n < 2000);
    check("accept", 32'(rdy), 1);
    e0 = cyc;
    check("load_hi", 32'(mul_loadA & mul_loadB), 1);
    check("rdy_lo", 32'(op_ready), 0);
    check("iA", 32'(mul_iA), 32'(a));
    check("iB", 32'(mul_iB), 32'(b));
  endtask

  task automatic get_res(input string tg,
                         input int exp,
                         input logic [7:0] a);
    int n;
    int ld0;
    n = 0;
    ld0 = nload;
    while (!res_valid && n < 2000) begin
      tick();
      n++;
    end
    check({tg, "_lat"}, 32'(cyc - e0), 257);
    check({tg, "_data"}, 32'(res_data), 32'(exp));
    check({tg, "_nload"}, 32'(nload - ld0), 1);
    check({tg, "_rdy"}, 32'(op_ready), 0);
    check({tg, "_iA"}, 32'(mul_iA), 32'(a));
    if (res_ready) begin
      tick();
      check({tg, "_vld0"}, 32'(res_valid), 0);
      check({tg, "_rdy1"}, 32'(op_ready), 1);
    end
  endtask

  initial begin
    int  prev;
    int  hs0;
    logic seen;

    // Reset state
    #2;
    check("rst_rdy", 32'(op_ready), 0);
    check("rst_vld", 32'(res_valid), 0);
    check("rst_data", 32'(res_data), 0);
    check("rst_load", 32'(mul_loadA | mul_loadB), 0);
    check("rst_iA", 32'(mul_iA), 0);
    repeat (3) tick();
    check("rst_hold_rdy", 32'(op_ready), 0);
    rst_n = 1'b1;
    tick();
    check("idle_rdy", 32'(op_ready), 1);

    // Zero operand gives zero
    send(8'h00, 8'hFF, 1'b1);
    op_valid = 1'b0;
    get_res("zero", 0, 8'h00);

    // Full scale
    send(8'hFF, 8'hFF, 1'b1);
    op_valid = 1'b0;
    get_res("full", 255, 8'hFF);

    // Backpressure with a pending operand ignored
    res_ready = 1'b0;
    send(8'hFF, 8'hFF, 1'b1);
    op_a = 8'h40;
    op_b = 8'h01;
    get_res("bp", 255, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("bp_data", 32'(res_data), 255);
      check("bp_vld", 32'(res_valid), 1);
      check("bp_rdy", 32'(op_ready), 0);
      check("bp_iA", 32'(mul_iA), 32'hFF);
    end
    res_ready = 1'b1;
    tick();
    check("bp_rel_vld", 32'(res_valid), 0);
    check("bp_rel_rdy", 32'(op_ready), 1);
    send(8'h40, 8'h01, 1'b1);
    op_valid = 1'b0;
    get_res("bp_next", 128, 8'h40);

    // Back-to-back with op_valid held
    send(8'h05, 8'h03, 1'b1);
    prev = e0;
    get_res("b2b0", 10, 8'h05);
    send(8'h80, 8'h01, 1'b1);
    check("b2b_sp1", 32'(e0 - prev), 259);
    prev = e0;
    get_res("b2b1", 255, 8'h80);
    send(8'h20, 8'h01, 1'b1);
    check("b2b_sp2", 32'(e0 - prev), 259);
    get_res("b2b2", 64, 8'h20);
    op_valid = 1'b0;

    // Reset during RUN at win_cnt==100
    send(8'h05, 8'h03, 1'b1);
    op_valid = 1'b0;
    repeat (101) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rdy", 32'(op_ready), 0);
    check("mid_vld", 32'(res_valid), 0);
    check("mid_data", 32'(res_data), 0);
    check("mid_iA", 32'(mul_iA), 0);
    check("mid_load", 32'(mul_loadA | mul_loadB), 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    check("mid_no_res", 32'(seen), 0);
    send(8'h7F, 8'h80, 1'b1);
    op_valid = 1'b0;
    get_res("mid_next", 254, 8'h7F);

`ifdef DMUL_ACC_EN
    // Accumulated dot products
    hs0 = nhs;
    send(8'h00, 8'hFF, 1'b0);
    send(8'h00, 8'h80, 1'b0);
    send(8'h00, 8'hFF, 1'b1);
    op_valid = 1'b0;
    get_res("acc0", 0, 8'h00);
    send(8'h40, 8'h01, 1'b0);
    send(8'h20, 8'h01, 1'b1);
    op_valid = 1'b0;
    get_res("acc1", 192, 8'h20);
    check("acc_nres", 32'(nhs - hs0), 2);
`else
    hs0 = nhs;
    send(8'h20, 8'h01, 1'b0);
    op_valid = 1'b0;
    get_res("nolast", 64, 8'h20);
    check("nolast_nres", 32'(nhs - hs0), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmul_uni_seq.md
Name: dmul_uni_seq

Overview:
- Operand sequencer and result capture for the unipolar LFSR-based stochastic multiplier.
- Accepts (A, B) operand pairs on a valid/ready interface and drives the multiplier's operand and load inputs.
- Times the stochastic window, captures the multiplier's coincidence count at the window end, and presents it on a valid/ready result interface.
- Sits directly between the operand source and the multiplier (upstream) and between the multiplier and the result consumer (downstream).

Parameters:
- DATAWD, 8, operand width; multiplier count width is 2*DATAWD.
- WIN_LEN, 255, accumulation edges per product (LFSR period); legal range 1..2^DATAWD.
- ACC_GUARD, 8, extra accumulator bits (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  block can accept an operand pair.
- op_a  in  DATAWD  operand A (unipolar, value/2^DATAWD).
- op_b  in  DATAWD  operand B.
- op_last  in  1  last pair of a dot product; ignored unless DMUL_ACC_EN.
- mul_iA  out  DATAWD  to multiplier iA.
- mul_iB  out  DATAWD  to multiplier iB.
- mul_loadA  out  1  to multiplier loadA.
- mul_loadB  out  1  to multiplier loadB.
- mul_oC  in  2*DATAWD  from multiplier oC.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  2*DATAWD+ACC_GUARD  result, zero-extended count (or accumulator).

Behaviour:
- Reset values: op_ready=0, mul_iA=0, mul_iB=0, mul_loadA=0, mul_loadB=0, res_valid=0, res_data=0. Internal state: FSM=IDLE, win_cnt=0, accumulator=0.
- op_ready=1 is a registered function of state==IDLE. It is low during reset.
- FSM states: IDLE, LOAD, RUN, CAP, OUT.
- IDLE:
  - op_ready=1.
  - On op_valid&op_ready, the edge latches op_a/op_b into mul_iA/mul_iB and the state moves to LOAD.
  - This is the acceptance edge, E0.
- LOAD (1 cycle):
  - mul_loadA=mul_loadB=1.
  - At edge E1, the multiplier latches its operands and clears oC.
  - The FSM moves to RUN with win_cnt=0.
  - mul_iA/mul_iB stay stable from E0 until the next acceptance.
- RUN:
  - win_cnt increments each edge.
  - At the edge where win_cnt==WIN_LEN-1, the state moves to CAP.
  - This gives exactly WIN_LEN accumulation edges, E2..E(WIN_LEN+1).
  - win_cnt is wide enough for 2^DATAWD and never wraps.
- CAP (1 cycle):
  - At edge E(WIN_LEN+2), mul_oC is captured into res_data and the state moves to OUT.
  - The multiplier keeps counting after this edge; the block never samples mul_oC at any other edge.
- OUT:
  - res_valid=1. res_data is held stable until res_valid&res_ready.
  - On handshake: res_valid drops at that edge and the state moves to IDLE (op_ready=1 the next cycle).
- Latency: res_valid rises WIN_LEN+2 cycles after E0. Throughput is one pair per WIN_LEN+4 cycles minimum.
- Backpressure: OUT holds indefinitely while res_ready=0. No operand is accepted in any state except IDLE.
- op_valid in non-IDLE states is ignored, with no side effects.
- Range: the result is always ≤ WIN_LEN.
  - If op_a==0 or op_b==0, the result is exactly 0.
- rst_n assert mid-operation (any state): all outputs return to reset values immediately; the in-flight pair is discarded and no partial result is emitted.
- mul_loadA/mul_loadB are never asserted outside LOAD.

Optional Feature:
- Macro: DMUL_ACC_EN.
- Defined:
  - In CAP, accumulator <= accumulator + mul_oC, saturating at all-ones of 2*DATAWD+ACC_GUARD bits.
  - op_last is latched at E0.
  - If the latched last=0, CAP goes directly to IDLE with no result.
  - If last=1, res_data=updated accumulator and the state enters OUT; the accumulator clears at the OUT handshake edge.
- Undefined: op_last is ignored, the accumulator is absent, and every pair produces res_data=mul_oC zero-extended.

Test Plan:
- Single pair A=8'h00, B=8'hFF, res_ready=1 -> res_valid exactly 257 cycles after E0 (WIN_LEN=255), res_data=0, mul_loadA/B high for one cycle only.
- A=8'hFF, B=8'hFF -> res_data in [250,255]; op_ready low from E0+1 until the cycle after the result handshake.
- Backpressure: hold res_ready=0 for 40 cycles after res_valid -> res_data stable, op_ready=0, new op_valid ignored; the release handshake returns to IDLE.
- Back-to-back: keep op_valid=1 with three pairs -> accepted spacing of WIN_LEN+4 cycles, results in order, mul_iA/iB unchanged between acceptances.
- Reset: rst_n low at win_cnt=100 -> outputs zero immediately, no res_valid after release; the next pair completes normally.
- DMUL_ACC_EN: pairs (0,FF,last=0), (0,80,last=0), (00,FF,last=1) -> one result, value 0; the 4th pair's result excludes earlier sums.
